// File: rtl/timekeeper_pkg.sv
// Shared types, limits and BCD step helpers for the timekeeper.
// Exports bcd_digit_t, bcd_pair_t, hour_next, hour_pm_flip, min_next.
package timekeeper_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t units;
    } bcd_pair_t;

    localparam int SECS_MAX      = 59;
    localparam int MINS_TENS_MAX = 5;
    localparam int H24_MAX       = 23;
    localparam int H12_MIN       = 1;
    localparam int H12_MAX       = 12;

    localparam bcd_digit_t H24_T  = bcd_digit_t'(H24_MAX / 10);
    localparam bcd_digit_t H24_U  = bcd_digit_t'(H24_MAX % 10);
    localparam bcd_digit_t H12X_T = bcd_digit_t'(H12_MAX / 10);
    localparam bcd_digit_t H12X_U = bcd_digit_t'(H12_MAX % 10);
    localparam bcd_digit_t H12N_T = bcd_digit_t'(H12_MIN / 10);
    localparam bcd_digit_t H12N_U = bcd_digit_t'(H12_MIN % 10);
    localparam bcd_digit_t H11_T  = bcd_digit_t'((H12_MAX - 1) / 10);
    localparam bcd_digit_t H11_U  = bcd_digit_t'((H12_MAX - 1) % 10);
    localparam bcd_digit_t MT_MAX = bcd_digit_t'(MINS_TENS_MAX);

    // Next hour in BCD; 12h runs 12,01..11,12 and 24h runs 00..23.
    function automatic bcd_pair_t hour_next(bcd_pair_t h, logic mode12);
        bcd_pair_t r;
        r = h;
        if (mode12 && h.tens == H12X_T && h.units == H12X_U) begin
            r.tens  = H12N_T;
            r.units = H12N_U;
        end else if (!mode12 && h.tens == H24_T && h.units == H24_U) begin
            r.tens  = 4'd0;
            r.units = 4'd0;
        end else if (h.units == 4'd9) begin
            r.tens  = h.tens + 4'd1;
            r.units = 4'd0;
        end else begin
            r.units = h.units + 4'd1;
        end
        return r;
    endfunction

    // AM/PM flips only on the 11 -> 12 step.
    function automatic logic hour_pm_flip(bcd_pair_t h, logic mode12);
        return mode12 && h.tens == H11_T && h.units == H11_U;
    endfunction

    function automatic bcd_pair_t min_next(bcd_pair_t m);
        bcd_pair_t r;
        r = m;
        if (m.units == 4'd9) begin
            r.units = 4'd0;
            r.tens  = (m.tens == MT_MAX) ? 4'd0 : m.tens + 4'd1;
        end else begin
            r.units = m.units + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-second tick.
// Ports: clk, reset (async high), run (enable), clear (sync zero), tick.
module tick_prescaler #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;

    // Tick is the terminal count while running; the caller masks it.
    assign tick = run && (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_timekeeper.sv
// BCD clock: hh:mm digits, binary seconds, optional 12h/PM, set pulses.
// Ports: CLK100MHZ, Reset, run, inc_hour, inc_min -> hours1/2, mins1/2,
// secs, pm, sec_tick. Macro TIMEKEEPER_ALARM_EN adds alarm_hours,
// alarm_mins, alarm_arm, alarm_ack inputs and the alarm output.
module bcd_timekeeper
    import timekeeper_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter bit MODE_12H = 0
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic       run,
    input  logic       inc_hour,
    input  logic       inc_min,
`ifdef TIMEKEEPER_ALARM_EN
    input  logic [7:0] alarm_hours,
    input  logic [7:0] alarm_mins,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output logic       alarm,
`endif
    output logic [3:0] hours1,
    output logic [3:0] hours2,
    output logic [3:0] mins1,
    output logic [3:0] mins2,
    output logic [5:0] secs,
    output logic       pm,
    output logic       sec_tick
);

    localparam bcd_pair_t HOUR_RST = MODE_12H ? {H12X_T, H12X_U} : 8'h00;

    bcd_pair_t  r_hours;
    bcd_pair_t  r_mins;
    logic [5:0] r_secs;
    logic       r_pm;
    logic       r_sec_tick;

    logic w_tick;
    logic w_sec_adv;
    logic w_sec_wrap;
    logic w_min_carry;
    logic w_min_adv;
    logic w_hour_adv;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (CLK100MHZ),
        .reset (Reset),
        .run   (run),
        .clear (inc_min),
        .tick  (w_tick)
    );

    // inc_min swallows a coincident tick, so it never carries.
    assign w_sec_adv   = w_tick && !inc_min;
    assign w_sec_wrap  = w_sec_adv && (r_secs == 6'(SECS_MAX));
    assign w_min_carry = w_sec_wrap && (r_mins == 8'h59);
    assign w_min_adv   = inc_min || w_sec_wrap;
    // A set pulse and a carry together still step the hour only once.
    assign w_hour_adv  = inc_hour || w_min_carry;

    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            r_hours    <= HOUR_RST;
            r_mins     <= '0;
            r_secs     <= '0;
            r_pm       <= 1'b0;
            r_sec_tick <= 1'b0;
        end else begin
            r_sec_tick <= w_sec_adv;
            if (inc_min) begin
                r_secs <= '0;
            end else if (w_sec_adv) begin
                r_secs <= w_sec_wrap ? 6'd0 : r_secs + 6'd1;
            end
            if (w_min_adv) begin
                r_mins <= min_next(r_mins);
            end
            if (w_hour_adv) begin
                r_hours <= hour_next(r_hours, MODE_12H);
                if (hour_pm_flip(r_hours, MODE_12H)) begin
                    r_pm <= ~r_pm;
                end
            end
        end
    end

    assign hours1   = r_hours.tens;
    assign hours2   = r_hours.units;
    assign mins1    = r_mins.tens;
    assign mins2    = r_mins.units;
    assign secs     = r_secs;
    assign pm       = r_pm;
    assign sec_tick = r_sec_tick;

`ifdef TIMEKEEPER_ALARM_EN
    logic r_alarm;
    logic r_match;
    logic w_match;

    assign w_match = alarm_arm && (r_hours == alarm_hours) &&
                     (r_mins == alarm_mins) && (r_secs == 6'd0);

    // Fire on the first matching cycle so an ack inside the
    // matching second is not immediately undone.
    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            r_alarm <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_match <= w_match;
            if (!alarm_arm || alarm_ack) begin
                r_alarm <= 1'b0;
            end else if (w_match && !r_match) begin
                r_alarm <= 1'b1;
            end
        end
    end

    assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Directed bench: 24h and 12h instances share stimulus, TICK_DIV=4.
// Ports driven: clk, rst, run, inc_hour, inc_min (+ alarm when enabled).
module tb_bcd_timekeeper;

    logic clk = 1'b0;
    logic rst, run, inc_hour, inc_min;
    logic [3:0] a_h1, a_h2, a_m1, a_m2, b_h1, b_h2, b_m1, b_m2;
    logic [5:0] a_secs, b_secs;
    logic a_pm, b_pm, a_st, b_st;
    logic [15:0] a_t, b_t;
    int n_vec = 0;
    int n_err = 0;
    int ticks;

    assign a_t = {a_h1, a_h2, a_m1, a_m2};
    assign b_t = {b_h1, b_h2, b_m1, b_m2};

`ifdef TIMEKEEPER_ALARM_EN
    logic [7:0] al_h, al_m;
    logic al_arm, al_ack, a_al, b_al;
`endif

    always #5 clk = ~clk;

    bcd_timekeeper #(.TICK_DIV(4), .MODE_12H(0)) u_a (
        .CLK100MHZ (clk), .Reset (rst), .run (run),
        .inc_hour (inc_hour), .inc_min (inc_min),
`ifdef TIMEKEEPER_ALARM_EN
        .alarm_hours (al_h), .alarm_mins (al_m),
        .alarm_arm (al_arm), .alarm_ack (al_ack), .alarm (a_al),
`endif
        .hours1 (a_h1), .hours2 (a_h2), .mins1 (a_m1), .mins2 (a_m2),
        .secs (a_secs), .pm (a_pm), .sec_tick (a_st)
    );

    bcd_timekeeper #(.TICK_DIV(4), .MODE_12H(1)) u_b (
        .CLK100MHZ (clk), .Reset (rst), .run (run),
        .inc_hour (inc_hour), .inc_min (inc_min),
`ifdef TIMEKEEPER_ALARM_EN
        .alarm_hours (al_h), .alarm_mins (al_m),
        .alarm_arm (al_arm), .alarm_ack (al_ack), .alarm (b_al),
`endif
        .hours1 (b_h1), .hours2 (b_h2), .mins1 (b_m1), .mins2 (b_m2),
        .secs (b_secs), .pm (b_pm), .sec_tick (b_st)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_min(input int n);
        repeat (n) begin
            inc_min = 1'b1;
            @(negedge clk);
            inc_min = 1'b0;
        end
    endtask

    task automatic pulse_hour(input int n);
        repeat (n) begin
            inc_hour = 1'b1;
            @(negedge clk);
            inc_hour = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        inc_hour = 1'b0;
        inc_min = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        inc_hour = 1'b0;
        inc_min = 1'b0;
`ifdef TIMEKEEPER_ALARM_EN
        al_h = 8'h00;
        al_m = 8'h00;
        al_arm = 1'b0;
        al_ack = 1'b0;
`endif
        @(negedge clk);
        chk("rst_a_time", a_t, 16'h0000);
        chk("rst_a_secs", a_secs, 0);
        chk("rst_a_tick", a_st, 0);
        chk("rst_b_time", b_t, 16'h1200);
        chk("rst_b_pm", b_pm, 0);

        // one full minute of ticks
        rst = 1'b0;
        run = 1'b1;
        ticks = 0;
        for (int k = 1; k <= 240; k++) begin
            @(negedge clk);
            if (a_st) ticks++;
            if (k == 3) chk("min_secs_k3", a_secs, 0);
            if (k == 4) chk("min_secs_k4", a_secs, 1);
            if (k == 4) chk("min_tick_k4", a_st, 1);
            if (k == 239) chk("min_secs_k239", a_secs, 59);
        end
        chk("min_a_time", a_t, 16'h0001);
        chk("min_a_secs", a_secs, 0);
        chk("min_ticks", ticks, 60);
        chk("min_b_time", b_t, 16'h1201);

        // 11:59:59 -> 12:00:00
        do_reset();
        pulse_hour(11);
        pulse_min(59);
        chk("pre11_a", a_t, 16'h1159);
        chk("pre11_b", b_t, 16'h1159);
        run = 1'b1;
        cyc(236);
        chk("pre11_secs", a_secs, 59);
        chk("pre11_bpm", b_pm, 0);
        cyc(4);
        chk("noon_a", a_t, 16'h1200);
        chk("noon_a_secs", a_secs, 0);
        chk("noon_a_pm", a_pm, 0);
        chk("noon_b", b_t, 16'h1200);
        chk("noon_b_pm", b_pm, 1);

        // 23:59:59 -> 00:00:00
        run = 1'b0;
        pulse_hour(11);
        pulse_min(59);
        run = 1'b1;
        cyc(236);
        chk("pre23_a", a_t, 16'h2359);
        chk("pre23_secs", a_secs, 59);
        chk("pre23_b", b_t, 16'h1159);
        chk("pre23_bpm", b_pm, 1);
        cyc(4);
        chk("midn_a", a_t, 16'h0000);
        chk("midn_secs", a_secs, 0);
        chk("midn_b", b_t, 16'h1200);
        chk("midn_bpm", b_pm, 0);

        // inc_min wrap and inc_min vs tick
        run = 1'b0;
        pulse_min(59);
        chk("imin59", a_t, 16'h0059);
        pulse_min(1);
        chk("imin_wrap_a", a_t, 16'h0000);
        chk("imin_wrap_b", b_t, 16'h1200);
        run = 1'b1;
        cyc(23);
        chk("pre_coll_secs", a_secs, 5);
        inc_min = 1'b1;
        @(negedge clk);
        inc_min = 1'b0;
        chk("coll_secs", a_secs, 0);
        chk("coll_tick", a_st, 0);
        chk("coll_time", a_t, 16'h0001);
        cyc(3);
        chk("coll_k3", a_secs, 0);
        cyc(1);
        chk("coll_k4", a_secs, 1);
        chk("coll_k4_tick", a_st, 1);

        // inc_hour coincident with the hour carry
        do_reset();
        pulse_hour(5);
        pulse_min(59);
        run = 1'b1;
        cyc(236);
        chk("pre05_a", a_t, 16'h0559);
        chk("pre05_secs", a_secs, 59);
        cyc(3);
        inc_hour = 1'b1;
        @(negedge clk);
        inc_hour = 1'b0;
        chk("hcoll_a", a_t, 16'h0600);
        chk("hcoll_secs", a_secs, 0);
        chk("hcoll_b", b_t, 16'h0600);
        cyc(8);
        chk("run_secs", a_secs, 2);
        run = 1'b0;
        cyc(50);
        chk("frozen_secs", a_secs, 2);
        pulse_min(1);
        chk("frozen_imin", a_t, 16'h0601);
        chk("frozen_imin_s", a_secs, 0);
        inc_hour = 1'b1;
        inc_min = 1'b1;
        @(negedge clk);
        inc_hour = 1'b0;
        inc_min = 1'b0;
        chk("both_inc", a_t, 16'h0702);

        // async reset mid-second at 12:34:56
        do_reset();
        pulse_hour(12);
        pulse_min(34);
        run = 1'b1;
        cyc(224);
        chk("pre_rst_a", a_t, 16'h1234);
        chk("pre_rst_s", a_secs, 56);
        chk("pre_rst_bpm", b_pm, 1);
        cyc(2);
        #2 rst = 1'b1;
        #1;
        chk("arst_a", a_t, 16'h0000);
        chk("arst_s", a_secs, 0);
        chk("arst_b", b_t, 16'h1200);
        chk("arst_bpm", b_pm, 0);
        chk("arst_tick", a_st, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(3);
        chk("post_rst_k3", a_secs, 0);
        cyc(1);
        chk("post_rst_k4", a_secs, 1);

`ifdef TIMEKEEPER_ALARM_EN
        do_reset();
        al_h = 8'h07;
        al_m = 8'h30;
        pulse_hour(7);
        pulse_min(29);
        al_arm = 1'b1;
        run = 1'b1;
        cyc(240);
        chk("al_time", a_t, 16'h0730);
        chk("al_secs", a_secs, 0);
        chk("al_early", a_al, 0);
        run = 1'b0;
        cyc(1);
        chk("al_set_a", a_al, 1);
        chk("al_set_b", b_al, 1);
        cyc(5);
        chk("al_hold", a_al, 1);
        al_ack = 1'b1;
        @(negedge clk);
        al_ack = 1'b0;
        chk("al_ack", a_al, 0);
        cyc(3);
        chk("al_stay", a_al, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
